// File: rtl/ui_cond_pkg.sv
// ----------------------------------------------------------------------------
// ui_cond_pkg
// Shared constants and helpers for the input-conditioning stage
// (ui_in_conditioner and its per-bit filter ui_debounce_bit).
//
// Contents:
//   SYNC_STAGES_MIN / SYNC_STAGES_MAX : legal synchronizer depth range
//   DEBOUNCE_MIN / DEBOUNCE_MAX       : legal debounce length range
//   cnt_width()                       : debounce counter width for a given
//                                       debounce length
// ----------------------------------------------------------------------------
package ui_cond_pkg;

    localparam int SYNC_STAGES_MIN = 2;
    localparam int SYNC_STAGES_MAX = 4;
    localparam int DEBOUNCE_MIN    = 1;
    localparam int DEBOUNCE_MAX    = 65535;

    // Width that holds DEBOUNCE_CYCLES-1 without overflow. The +1 keeps the
    // result at least 1 bit even when DEBOUNCE_CYCLES is 1 (counter unused
    // but still a legal vector).
    function automatic int cnt_width(input int debounce_cycles);
        int w;
        w = $clog2(debounce_cycles + 1);
        if (w < 1) begin
            w = 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/ui_debounce_bit.sv
// ----------------------------------------------------------------------------
// ui_debounce_bit
// Conditions one raw pad input: a SYNC_STAGES-deep synchronizer followed by a
// debounce filter that only accepts a new level after the synchronized value
// has differed from the accepted level for DEBOUNCE_CYCLES consecutive
// cycles. Emits registered one-cycle rise/fall pulses aligned with the level
// change.
//
// Ports:
//   clk_i        : system clock
//   rst_i        : synchronous active-high reset
//   ena_i        : filter enable; low holds the counter at 0, the level
//                  steady and the pulses low (synchronizer keeps running)
//   pin_i        : raw asynchronous pad input
//   level_o      : debounced level
//   rise_o       : one-cycle pulse in the cycle level_o first reads 1
//   fall_o       : one-cycle pulse in the cycle level_o first reads 0
//   pulse_next_o : next-cycle value of (rise_o | fall_o), so the parent can
//                  register an aggregate edge flag in the same cycle
// ----------------------------------------------------------------------------
module ui_debounce_bit
    import ui_cond_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic ena_i,
    input  logic pin_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o,
    output logic pulse_next_o
);

    localparam int              CNT_W    = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    logic                   sync_s;

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             level_q;
    logic             level_d;
    logic             rise_q;
    logic             rise_d;
    logic             fall_q;
    logic             fall_d;

    // Shift register: bit 0 takes the raw pin, the top bit is the
    // synchronized value used by the filter.
    assign sync_d = {sync_q[SYNC_STAGES-2:0], pin_i};
    assign sync_s = sync_q[SYNC_STAGES-1];

    always_comb begin
        cnt_d   = cnt_q;
        level_d = level_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;

        if (!ena_i) begin
            // Frozen: any partial count is discarded so filtering restarts
            // from zero when enabled again.
            cnt_d = '0;
        end else if (sync_s == level_q) begin
            // Any return to equality throws away accumulated credit.
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            level_d = sync_s;
            cnt_d   = '0;
            rise_d  = sync_s;
            fall_d  = ~sync_s;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q  <= '0;
            cnt_q   <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign level_o      = level_q;
    assign rise_o       = rise_q;
    assign fall_o       = fall_q;
    assign pulse_next_o = rise_d | fall_d;

endmodule

// File: rtl/ui_in_conditioner.sv
// ----------------------------------------------------------------------------
// ui_in_conditioner
// Input-conditioning stage for the 8-bit dedicated input bus. Every raw pin
// is synchronized and debounced independently; the block presents a clean
// level bus plus per-bit one-cycle rise/fall pulses and a registered
// any-edge flag.
//
// Parameters:
//   WIDTH           : number of conditioned bits
//   SYNC_STAGES     : synchronizer depth per bit (2..4)
//   DEBOUNCE_CYCLES : consecutive differing cycles needed to accept a new
//                     level (1..65535)
//
// Ports:
//   clk       : system clock (single domain)
//   rst       : synchronous active-high reset
//   ena       : conditioning enable; low freezes the filters
//   pin_in    : raw asynchronous pad inputs
//   level_out : debounced, synchronized levels
//   rise_out  : one-cycle pulse per bit on an accepted 0->1 change
//   fall_out  : one-cycle pulse per bit on an accepted 1->0 change
//   any_edge  : registered OR of all pulses, high in the same cycle as them
//
// Latency for a stable pin change: SYNC_STAGES + DEBOUNCE_CYCLES cycles.
// ----------------------------------------------------------------------------
module ui_in_conditioner
    import ui_cond_pkg::*;
#(
    parameter int WIDTH           = 8,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ena,
    input  logic [WIDTH-1:0] pin_in,
    output logic [WIDTH-1:0] level_out,
    output logic [WIDTH-1:0] rise_out,
    output logic [WIDTH-1:0] fall_out,
    output logic             any_edge
);

    // Reject illegal parameterisations at elaboration.
    if (SYNC_STAGES < SYNC_STAGES_MIN || SYNC_STAGES > SYNC_STAGES_MAX) begin : g_bad_sync
        $error("ui_in_conditioner: SYNC_STAGES=%0d outside %0d..%0d",
               SYNC_STAGES, SYNC_STAGES_MIN, SYNC_STAGES_MAX);
    end
    if (DEBOUNCE_CYCLES < DEBOUNCE_MIN || DEBOUNCE_CYCLES > DEBOUNCE_MAX) begin : g_bad_deb
        $error("ui_in_conditioner: DEBOUNCE_CYCLES=%0d outside %0d..%0d",
               DEBOUNCE_CYCLES, DEBOUNCE_MIN, DEBOUNCE_MAX);
    end
    if (WIDTH < 1) begin : g_bad_width
        $error("ui_in_conditioner: WIDTH must be at least 1");
    end

    logic [WIDTH-1:0] pulse_next;
    logic             any_edge_q;
    logic             any_edge_d;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        ui_debounce_bit #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_bit (
            .clk_i        (clk),
            .rst_i        (rst),
            .ena_i        (ena),
            .pin_i        (pin_in[i]),
            .level_o      (level_out[i]),
            .rise_o       (rise_out[i]),
            .fall_o       (fall_out[i]),
            .pulse_next_o (pulse_next[i])
        );
    end

    // Built from the per-bit next-state pulses so the flag is a flop of its
    // own yet lines up with the pulse registers.
    assign any_edge_d = |pulse_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            any_edge_q <= 1'b0;
        end else begin
            any_edge_q <= any_edge_d;
        end
    end

    assign any_edge = any_edge_q;

endmodule

// File: tb/tb_ui_in_conditioner.sv
// ----------------------------------------------------------------------------
// tb_ui_in_conditioner
// Directed bench for ui_in_conditioner with default parameters
// (WIDTH=8, SYNC_STAGES=2, DEBOUNCE_CYCLES=4 -> 6-cycle latency).
// Inputs change on the falling edge; outputs are sampled on the falling edge
// after each rising edge, so "step k" means the k-th rising edge after the
// input change has been applied.
// ----------------------------------------------------------------------------
module tb_ui_in_conditioner;

    // ---------------- clock / reset ----------------
    logic       clk;
    logic       rst;
    logic       ena;
    logic [7:0] pin_in;
    logic [7:0] level_out;
    logic [7:0] rise_out;
    logic [7:0] fall_out;
    logic       any_edge;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    ui_in_conditioner #(
        .WIDTH           (8),
        .SYNC_STAGES     (2),
        .DEBOUNCE_CYCLES (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ena       (ena),
        .pin_in    (pin_in),
        .level_out (level_out),
        .rise_out  (rise_out),
        .fall_out  (fall_out),
        .any_edge  (any_edge)
    );

    // ---------------- scoreboard ----------------
    int         n_checked = 0;
    int         n_failed  = 0;
    logic [3:0] exp_q[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checked++;
        if (got !== exp) begin
            n_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Drives pin_in[b] from pat (bit k-1 before step k) for n steps and checks
    // {level[b], rise[b], fall[b], any_edge} each step. rise_at / fall_at are
    // the hand-computed steps of the accepted changes (0 = none).
    task automatic run_bit(input string tag, input int b, input logic [63:0] pat,
                           input int n, input logic lvl0, input int rise_at,
                           input int fall_at);
        logic       lvl;
        logic       r;
        logic       f;
        logic [3:0] got;
        lvl = lvl0;
        for (int k = 1; k <= n; k++) begin
            r = (k == rise_at);
            f = (k == fall_at);
            if (r) lvl = 1'b1;
            if (f) lvl = 1'b0;
            exp_q.push_back({lvl, r, f, r | f});
        end
        for (int k = 1; k <= n; k++) begin
            pin_in[b] = pat[k-1];
            step();
            got = {level_out[b], rise_out[b], fall_out[b], any_edge};
            check_eq($sformatf("%s k=%0d", tag, k), 32'(got), 32'(exp_q.pop_front()));
        end
    endtask

    // Checks the whole bus after one step.
    task automatic check_bus(input string tag, input logic [7:0] lvl, input logic [7:0] r,
                             input logic [7:0] f, input logic a);
        check_eq({tag, " level"}, 32'(level_out), 32'(lvl));
        check_eq({tag, " rise"},  32'(rise_out),  32'(r));
        check_eq({tag, " fall"},  32'(fall_out),  32'(f));
        check_eq({tag, " any"},   32'(any_edge),  32'(a));
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        rst    = 1'b1;
        ena    = 1'b1;
        pin_in = 8'hFF;
        step();
        step();
        check_bus("in_reset", 8'h00, 8'h00, 8'h00, 1'b0);

        // Pins held high through reset release: rise on all bits at step 6.
        rst = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            step();
            check_bus($sformatf("rst_rel k=%0d", k),
                      (k >= 6) ? 8'hFF : 8'h00,
                      (k == 6) ? 8'hFF : 8'h00,
                      8'h00, (k == 6));
        end

        // All pins low: fall on all bits at step 6.
        pin_in = 8'h00;
        for (int k = 1; k <= 7; k++) begin
            step();
            check_bus($sformatf("all_fall k=%0d", k),
                      (k >= 6) ? 8'h00 : 8'hFF,
                      8'h00,
                      (k == 6) ? 8'hFF : 8'h00, (k == 6));
        end

        // Clean edges on bit 3.
        run_bit("rise3", 3, '1, 8, 1'b0, 6, 0);
        run_bit("fall3", 3, '0, 8, 1'b1, 0, 6);

        // Glitches on bit 0: 3 cycles rejected, 4 cycles accepted.
        run_bit("glitch3", 0, 64'h7, 12, 1'b0, 0, 0);
        run_bit("glitch4", 0, 64'hF, 13, 1'b0, 6, 10);

        // Bounce on bit 5: 20 single-cycle toggles, then held high.
        run_bit("bounce5", 5, {44'hFFF_FFFF_FFFF, 20'h55555}, 28, 1'b0, 26, 0);

        // Enable dropped with a change on bit 1 in flight.
        pin_in[1] = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            step();
            check_bus($sformatf("ena_pre k=%0d", k), 8'h20, 8'h00, 8'h00, 1'b0);
        end
        ena = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            step();
            check_bus($sformatf("ena_off k=%0d", k), 8'h20, 8'h00, 8'h00, 1'b0);
        end
        ena = 1'b1;
        run_bit("ena_on", 1, '1, 6, 1'b0, 4, 0);

        // Simultaneous rise on bits 4 and 6.
        pin_in = 8'h72;
        for (int k = 1; k <= 7; k++) begin
            step();
            check_bus($sformatf("multi k=%0d", k),
                      (k >= 6) ? 8'h72 : 8'h22,
                      (k == 6) ? 8'h50 : 8'h00,
                      8'h00, (k == 6));
        end

        // Reset while bit 7 is at count 2.
        pin_in = 8'hF2;
        for (int k = 1; k <= 4; k++) begin
            step();
            check_bus($sformatf("pend7 k=%0d", k), 8'h72, 8'h00, 8'h00, 1'b0);
        end
        rst = 1'b1;
        step();
        check_bus("mid_rst", 8'h00, 8'h00, 8'h00, 1'b0);
        step();
        rst = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            step();
            check_bus($sformatf("post_rst k=%0d", k),
                      (k >= 6) ? 8'hF2 : 8'h00,
                      (k == 6) ? 8'hF2 : 8'h00,
                      8'h00, (k == 6));
        end

        // ---------------- final report ----------------
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checked, n_failed);
        $finish;
    end

endmodule
